// File: rtl/tap_sequencer.sv
// Modulo-MODULUS up/down tap sequencer with free-run and one-shot sweeps,
// parallel load, and registered wrap/done strobes for the band filter MACs.
module tap_sequencer #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_enable,
    input  logic             mode,
    input  logic             count_down,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] current_count,
    output logic             first,
    output logic             last,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] load_clamped;
    logic             at_terminal;

    // Stepping past the terminal lands on the start value, which is exactly the
    // modulo-MODULUS wrap, so the adder never has to leave 0..MODULUS-1.
    always_comb begin
        start_value  = count_down ? MAX_COUNT : '0;
        terminal     = count_down ? '0 : MAX_COUNT;
        at_terminal  = (current_count == terminal);
        load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        if (at_terminal)
            stepped = start_value;
        else if (count_down)
            stepped = current_count - WIDTH'(1);
        else
            stepped = current_count + WIDTH'(1);
    end

    assign first = (current_count == start_value);
    assign last  = at_terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            current_count <= MAX_COUNT;
            state         <= IDLE;
            busy          <= 1'b0;
            wrap          <= 1'b0;
            done          <= 1'b0;
        end else begin
            // Strobes live for exactly one clock, independent of clk_enable.
            wrap <= 1'b0;
            done <= 1'b0;
            if (clk_enable) begin
                if (load) begin
                    current_count <= load_clamped;
                end else if (!mode) begin
                    state         <= RUN;
                    busy          <= 1'b1;
                    current_count <= stepped;
                    wrap          <= at_terminal;
                end else if (state == IDLE) begin
                    if (start) begin
                        current_count <= start_value;
                        state         <= RUN;
                        busy          <= 1'b1;
                    end
                end else if (at_terminal) begin
                    // One-shot sweep ends: hold at terminal, no wrap.
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    current_count <= stepped;
                end
            end
        end
    end

endmodule

// File: tb/tb_tap_sequencer.sv
// Bench for tap_sequencer: three instances (M=64, M=10, M=40) share stimulus
// and are compared every cycle with a behavioural model, plus vectors and sequences.
module tb_tap_sequencer;

    logic       clk = 1'b0;
    logic       rst, en, mode, dn, start, load;
    logic [5:0] lv;
    logic [5:0] c64, c40;
    logic [3:0] c10;
    logic [2:0] fi, la, wr, bz, dne;

    int checks = 0;
    int errors = 0;

    localparam int MODS [3] = '{64, 10, 40};
    localparam int MASKS[3] = '{63, 15, 63};

    // behavioural state: count value, sweep active, strobes
    int mc [3];
    bit mrun[3], mw[3], md[3];

    always #5 clk = ~clk;

    tap_sequencer #(.WIDTH(6), .MODULUS(64)) dut64 (
        .clk(clk), .rst(rst), .clk_enable(en), .mode(mode), .count_down(dn),
        .start(start), .load(load), .load_value(lv), .current_count(c64),
        .first(fi[0]), .last(la[0]), .wrap(wr[0]), .busy(bz[0]), .done(dne[0]));

    tap_sequencer #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .rst(rst), .clk_enable(en), .mode(mode), .count_down(dn),
        .start(start), .load(load), .load_value(lv[3:0]), .current_count(c10),
        .first(fi[1]), .last(la[1]), .wrap(wr[1]), .busy(bz[1]), .done(dne[1]));

    tap_sequencer #(.WIDTH(6), .MODULUS(40)) dut40 (
        .clk(clk), .rst(rst), .clk_enable(en), .mode(mode), .count_down(dn),
        .start(start), .load(load), .load_value(lv), .current_count(c40),
        .first(fi[2]), .last(la[2]), .wrap(wr[2]), .busy(bz[2]), .done(dne[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int cnt_of(input int i);
        case (i)
            0:       return int'(c64);
            1:       return int'(c10);
            default: return int'(c40);
        endcase
    endfunction

    function automatic void model_edge(input int i, input bit r, e, m, d, s, ld, input int v);
        int m_max, sv, tv;
        m_max = MODS[i] - 1;
        sv = d ? m_max : 0;
        tv = d ? 0 : m_max;
        if (r) begin
            mc[i] = m_max; mrun[i] = 0; mw[i] = 0; md[i] = 0;
            return;
        end
        mw[i] = 0;
        md[i] = 0;
        if (!e) return;
        if (ld) begin
            mc[i] = ((v & MASKS[i]) < m_max) ? (v & MASKS[i]) : m_max;
        end else if (!m) begin
            mrun[i] = 1;
            mc[i]   = d ? (mc[i] + m_max) % MODS[i] : (mc[i] + 1) % MODS[i];
            mw[i]   = (mc[i] == sv);
        end else if (!mrun[i]) begin
            if (s) begin
                mc[i] = sv; mrun[i] = 1;
            end
        end else if (mc[i] == tv) begin
            mrun[i] = 0; md[i] = 1;
        end else begin
            mc[i] = d ? mc[i] - 1 : mc[i] + 1;
        end
    endfunction

    // One clock: drive inputs, take the edge, update model, compare all instances.
    task automatic step(input bit r, e, m, d, s, ld, input logic [5:0] v);
        int act, exp, m_max;
        rst = r; en = e; mode = m; dn = d; start = s; load = ld; lv = v;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, r, e, m, d, s, ld, int'(v));
        #1;
        for (int i = 0; i < 3; i++) begin
            m_max = MODS[i] - 1;
            act = (cnt_of(i) << 5) | {27'd0, bz[i], wr[i], dne[i], fi[i], la[i]};
            exp = (mc[i] << 5) | {27'd0, mrun[i], mw[i], md[i],
                                  mc[i] == (d ? m_max : 0), mc[i] == (d ? 0 : m_max)};
            chk($sformatf("model_M%0d {cnt,busy,wrap,done,first,last}", MODS[i]), act, exp);
        end
    endtask

    typedef struct {
        bit         r, e, m, d, s, ld;
        logic [5:0] v;
        int         cnt;
        bit         b, w, dn;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int wraps, viol, maxc, edges, done_edges, done_cnt, after;
        bit e, rm, rd;

        rst = 1; en = 0; mode = 0; dn = 0; start = 0; load = 0; lv = '0;
        for (int i = 0; i < 3; i++) begin
            mc[i] = MODS[i] - 1; mrun[i] = 0; mw[i] = 0; md[i] = 0;
        end

        // Vectors for the M=10 instance: r e m d s ld v | cnt busy wrap done
        tbl[0]  = '{1,0,0,0,0,0, 6'd0,  9,0,0,0};
        tbl[1]  = '{0,1,1,0,0,0, 6'd0,  9,0,0,0};
        tbl[2]  = '{0,1,1,0,1,0, 6'd0,  0,1,0,0};
        tbl[3]  = '{0,1,1,0,0,0, 6'd0,  1,1,0,0};
        tbl[4]  = '{0,0,1,0,0,0, 6'd0,  1,1,0,0};
        tbl[5]  = '{0,1,1,0,0,1, 6'd7,  7,1,0,0};
        tbl[6]  = '{0,1,1,0,0,0, 6'd0,  8,1,0,0};
        tbl[7]  = '{0,1,1,0,1,0, 6'd0,  9,1,0,0};
        tbl[8]  = '{0,1,1,0,0,0, 6'd0,  9,0,0,1};
        tbl[9]  = '{0,0,1,0,0,0, 6'd0,  9,0,0,0};
        tbl[10] = '{0,1,0,0,0,0, 6'd0,  0,1,1,0};
        tbl[11] = '{0,1,0,1,0,0, 6'd0,  9,1,1,0};
        tbl[12] = '{0,1,0,1,0,0, 6'd0,  8,1,0,0};
        tbl[13] = '{0,1,0,1,0,1, 6'd15, 9,1,0,0};
        tbl[14] = '{0,1,1,1,0,0, 6'd0,  8,1,0,0};
        tbl[15] = '{0,1,1,0,0,0, 6'd0,  9,1,0,0};
        tbl[16] = '{0,1,1,0,0,1, 6'd3,  3,1,0,0};
        tbl[17] = '{0,0,1,0,0,0, 6'd0,  3,1,0,0};
        tbl[18] = '{1,1,1,0,0,0, 6'd0,  9,0,0,0};

        for (int k = 0; k < 19; k++) begin
            step(tbl[k].r, tbl[k].e, tbl[k].m, tbl[k].d, tbl[k].s, tbl[k].ld, tbl[k].v);
            chk($sformatf("vec%0d {cnt,busy,wrap,done}", k),
                {int'(c10), 3'(0), bz[1], wr[1], dne[1]},
                {tbl[k].cnt, 3'(0), tbl[k].b, tbl[k].w, tbl[k].dn});
        end

        // Reset for two cycles
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("reset_M64 {cnt,busy,wrap,done,last}",
            {int'(c64), 4'(0), bz[0], wr[0], dne[0], la[0]}, {63, 4'(0), 4'b0001});

        // Free-run up, M=64: wrap only when 0 is shown, once every 64 cycles
        wraps = 0; viol = 0;
        for (int k = 0; k < 130; k++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            if (wr[0]) wraps++;
            if (wr[0] != (c64 == 6'd0)) viol++;
        end
        chk("freerun_up_M64 wraps", wraps, 3);
        chk("freerun_up_M64 wrap_not_on_zero", viol, 0);

        // Free-run down, M=10: never leaves 0..9, wrap on each 9
        step(1, 1, 0, 1, 0, 0, 0);
        wraps = 0; viol = 0; maxc = 0;
        for (int k = 0; k < 25; k++) begin
            step(0, 1, 0, 1, 0, 0, 0);
            if (int'(c10) > maxc) maxc = int'(c10);
            if (wr[1]) wraps++;
            if (wr[1] != (c10 == 4'd9)) viol++;
        end
        chk("freerun_down_M10 max_count", maxc, 9);
        chk("freerun_down_M10 wraps", wraps, 2);
        chk("freerun_down_M10 wrap_not_on_nine", viol, 0);

        // One-shot up, M=10, enable toggling, second start mid-run ignored
        step(1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0, 0);
        edges = 1; done_edges = 0; done_cnt = 0; after = 0;
        for (int k = 0; k < 100 && after < 4; k++) begin
            e = (k % 2) == 1;
            step(0, e, 1, 0, (k == 7), 0, 0);
            if (e) edges++;
            if (dne[1]) begin
                done_cnt++;
                if (done_edges == 0) done_edges = edges;
                chk("oneshot_M10 count_at_done", int'(c10), 9);
            end
            if (done_cnt > 0) after++;
        end
        chk("oneshot_M10 enabled_edges_to_done", done_edges, 11);
        chk("oneshot_M10 done_pulses", done_cnt, 1);

        // Reset mid one-shot at count 5: abort, no done
        step(0, 1, 1, 0, 1, 0, 0);
        for (int k = 0; k < 20 && c10 != 4'd5; k++) step(0, 1, 1, 0, 0, 0, 0);
        chk("abort_M10 reached_5", int'(c10), 5);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("abort_M10 {cnt,busy,done}", {int'(c10), 1'b0, bz[1], dne[1]}, {9, 3'b000});
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 0, 0, 0, 0);
            if (dne[1]) done_cnt++;
        end
        chk("abort_M10 no_done_after", done_cnt + int'(bz[1]), 0);

        // Load clamps to MODULUS-1
        step(0, 1, 1, 0, 0, 1, 6'd50);
        chk("load50_M40 clamped", int'(c40), 39);
        chk("load50_M64 unclamped", int'(c64), 50);
        chk("load50_M10 low_bits", int'(c10), 2);

        // Randomised run against the model
        step(1, 1, 0, 0, 0, 0, 0);
        rm = 0; rd = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) rm = ~rm;
            if ($urandom_range(0, 29) == 0) rd = ~rd;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rm, rd,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                 6'($urandom_range(0, 63)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_sequencer.md
# tap_sequencer

Parametrised successor to the equalizer's 6-bit tap counter: a modulo-N up/down sequencer with free-running and one-shot modes, parallel load, and terminal/wrap strobes. It drives tap indexing for the time-multiplexed MAC in each band filter. Its one-shot start/done handshake lets a filter channel run exactly one tap sweep per input sample.

## Interface
Parameters:
- WIDTH, 6, count width; WIDTH >= clog2(MODULUS)
- MODULUS, 64, count range 0..MODULUS-1; 2 <= MODULUS <= 2^WIDTH, need not be a power of two

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- clk_enable  input  1  qualifies count/start/load; nothing advances when 0
- mode  input  1  0 = free-run, 1 = one-shot
- count_down  input  1  0 = count up, 1 = count down
- start  input  1  one-shot launch request
- load  input  1  parallel load request
- load_value  input  WIDTH  value for load
- current_count  output  WIDTH  registered count
- first  output  1  combinational: current_count == start value (0 up, MODULUS-1 down)
- last  output  1  combinational: current_count == terminal (MODULUS-1 up, 0 down)
- wrap  output  1  registered one-cycle pulse on a modulo wrap
- busy  output  1  registered: state RUN
- done  output  1  registered one-cycle pulse at end of one-shot sweep

## Operation
- Reset (rst=1 at edge, overrides all): current_count = MODULUS-1, state IDLE, busy=0, wrap=0, done=0.
- States: IDLE, RUN. busy = (state == RUN).
- Priority on an edge with clk_enable=1: load > state action.
- Load: current_count <= min(load_value, MODULUS-1). State unchanged. wrap not asserted.
- Free-run (mode=0):
  - State forced to RUN.
  - Every enabled edge: up: MODULUS-1 -> 0, else +1; down: 0 -> MODULUS-1, else -1.
  - wrap=1 for the cycle in which the wrapped value is shown.
- One-shot (mode=1):
  - IDLE: count holds. start=1 on an enabled edge -> count <= start value, state RUN.
  - RUN: each enabled edge advances by one toward terminal, with no wrap. The enabled edge on which count == terminal -> state IDLE, count holds at terminal, done=1 for one cycle, wrap stays 0.
  - start in RUN is ignored.
- Mode 1->0 in IDLE: enters RUN on the next edge and advances from the held value.
- Mode 0->1 in RUN: continues to terminal, then finishes as one-shot, with done asserted.
- count_down change mid-run: takes effect on the next enabled edge; terminal and start are re-evaluated.
- Arithmetic is modulo MODULUS, never modulo 2^WIDTH. current_count never exceeds MODULUS-1.
- wrap and done are plain clock-cycle pulses: they are cleared on the next edge regardless of clk_enable.

## Timing
- current_count, busy, wrap and done are all registered with 1-edge latency from the qualifying edge. first and last are zero-latency decodes of current_count.
- One-shot up sweep: the start edge shows 0. Then M-1 more enabled edges reach MODULUS-1, and one more enabled edge gives busy 1->0 and done=1. Total MODULUS+1 enabled edges from start to done.
- clk_enable=0 stalls everything except wrap/done clearing. Gaps stretch the sweep but do not change its count.
- Reset mid-sweep aborts with no done pulse and returns to reset values on that edge.
- load in RUN on the terminal edge: load wins and the sweep continues from the loaded value with no done. Load in IDLE does not start a sweep.

## Test plan
- Reset: rst=1 for 2 cycles with MODULUS=64 -> count=63, busy=0, wrap=0, done=0, last=1 (up).
- Free-run up, MODULUS=64, clk_enable=1 -> 63,0,1,…,63,0; wrap pulses exactly on each 0, every 64 cycles.
- Free-run down, MODULUS=10, WIDTH=4 -> 9,8,…,0,9; wrap on each 9; count never reaches 10..15.
- One-shot up, MODULUS=10, clk_enable toggling every other cycle, start pulse -> counts 0..9, done once after 11 enabled edges; a second start mid-run is ignored.
- Load: load_value=50 with MODULUS=40 -> count=39. A load on the terminal edge of a sweep suppresses done.
- Reset mid one-shot at count=5 -> count=MODULUS-1, busy=0, no done pulse.
